// File: rtl/serial_to_parallel.sv
// Serial-to-parallel receiver: assembles MSB-first serial words framed by a
// one-cycle SSPFSSIN pulse and hands them to a receive FIFO.
module serial_to_parallel #(
  parameter int N = 8
) (
  input  logic         SSPCLKIN,
  input  logic         CLEAR,
  input  logic         SSPRXD,
  input  logic         SSPFSSIN,
  input  logic         rx_full,
  output logic [N-1:0] RxData,
  output logic         rx_write,
  output logic         rx_overrun,
  output logic         framing_err,
  output logic         rx_busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_shift;
  logic [N-1:0]   r_rxdata;
  logic           r_write;
  logic           r_overrun;
  logic           r_ferr;
  logic           r_busy;

  logic           w_last;
  logic [N-1:0]   w_word;

  // The edge that samples the LSB is the one where the counter reaches N-1.
  assign w_last = (r_cnt == CW'(N - 1));
  assign w_word = {r_shift[N-2:0], SSPRXD};

  // Receive FSM, shift register, counter and registered outputs.
  always_ff @(posedge SSPCLKIN) begin
    if (CLEAR) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_rxdata  <= '0;
      r_write   <= 1'b0;
      r_overrun <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_write   <= 1'b0;
      r_overrun <= 1'b0;
      r_ferr    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (SSPFSSIN) begin
            r_state <= SHIFT;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_last) begin
            // Word completes; a frame pulse here chains the next word with no gap.
            r_shift <= w_word;
            r_cnt   <= '0;
            if (rx_full) begin
              r_overrun <= 1'b1;
            end else begin
              r_rxdata <= w_word;
              r_write  <= 1'b1;
            end
            if (SSPFSSIN) begin
              r_state <= SHIFT;
              r_busy  <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else if (SSPFSSIN) begin
            r_ferr <= 1'b1;
            r_cnt  <= '0;
          end else begin
            r_shift <= w_word;
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign RxData      = r_rxdata;
  assign rx_write    = r_write;
  assign rx_overrun  = r_overrun;
  assign framing_err = r_ferr;
  assign rx_busy     = r_busy;

endmodule
